// File: rtl/banked_mem_sync.sv
// banked_mem_sync: NUM_BANKS-lane masked scratch memory with registered read, post-reset clear sweep and range check.
// Define BANKED_MEM_SYNC_BYPASS_EN for write-first per-lane forwarding on read/write collisions (default read-first).
module banked_mem_sync #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            read,
  input  logic                            write,
  input  logic [NUM_BANKS-1:0]            wr_mask,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [NUM_BANKS*BANK_WIDTH-1:0] data_in,
  output logic [NUM_BANKS*BANK_WIDTH-1:0] data_out,
  output logic                            rd_valid,
  output logic                            ready,
  output logic                            addr_err
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] last_addr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   depth_ext = (ADDR_WIDTH + 1)'(DEPTH);
  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] cnt, wr_addr;
  logic                  in_range, clr, acc, rd_en, wr_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= clr ? cnt + 1'b1 : cnt;
      ready <= next_state == RUN;
    end
  end
  always_comb next_state = (state == INIT && cnt == last_addr) ? RUN : state;
  // Commands are only honoured in RUN; the sweep owns the write port during INIT.
  always_comb begin
    in_range = {1'b0, address} < depth_ext;
    clr      = state == INIT;
    acc      = state == RUN && !reset;
    rd_en    = acc && read;
    wr_en    = acc && write && in_range;
    wr_addr  = clr ? cnt : address;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      addr_err <= acc && (read || write) && !in_range;
    end
  end
  for (genvar i = 0; i < NUM_BANKS; i++) begin : BANK
    logic [BANK_WIDTH-1:0] mem [DEPTH];
    logic [BANK_WIDTH-1:0] din, stored, q;
    logic                  fwd;
    assign din    = data_in[i*BANK_WIDTH +: BANK_WIDTH];
    assign stored = mem[address];
`ifdef BANKED_MEM_SYNC_BYPASS_EN
    assign fwd = write && wr_mask[i];
`else
    assign fwd = 1'b0;
`endif
    always_ff @(posedge clk) begin
      if (clr || (wr_en && wr_mask[i])) mem[wr_addr] <= clr ? '0 : din;
    end
    always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else if (rd_en) q <= in_range ? (fwd ? din : stored) : '0;
    end
    assign data_out[i*BANK_WIDTH +: BANK_WIDTH] = q;
  end
endmodule

// File: tb/tb_banked_mem_sync.sv
// tb_banked_mem_sync: vector table, scoreboard-checked random traffic and corner sequences for banked_mem_sync.
module tb_banked_mem_sync;
  logic        clk = 1'b0;
  logic        reset, read, write, rd_valid, ready, addr_err;
  logic [3:0]  wr_mask, address;
  logic [31:0] data_in, data_out;
  logic        reset2, read2, write2, rd_valid2, ready2, addr_err2;
  logic [3:0]  wr_mask2, address2;
  logic [31:0] data_in2, data_out2;
  int          passed = 0, total = 0;
  logic [31:0] ref_mem [16];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  typedef struct {
    logic r, w; logic [3:0] m, a; logic [31:0] d; logic ev; logic [31:0] ed;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  banked_mem_sync u_dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .wr_mask(wr_mask),
    .address(address), .data_in(data_in), .data_out(data_out),
    .rd_valid(rd_valid), .ready(ready), .addr_err(addr_err));
  banked_mem_sync #(.DEPTH(12)) u_d12 (
    .clk(clk), .reset(reset2), .read(read2), .write(write2), .wr_mask(wr_mask2),
    .address(address2), .data_in(data_in2), .data_out(data_out2),
    .rd_valid(rd_valid2), .ready(ready2), .addr_err(addr_err2));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic w, input logic [3:0] m, input logic [3:0] a, input logic [31:0] d);
    read = r; write = w; wr_mask = m; address = a; data_in = d;
  endtask
  task automatic drive2(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
    read2 = r; write2 = w; wr_mask2 = 4'hF; address2 = a; data_in2 = d;
  endtask
  // Reference: a word store of 16 entries; a masked write replaces whole bytes of the word.
  task automatic apply(input logic r, input logic w, input logic [3:0] m, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] old, merged;
    drive(r, w, m, a, d);
    tick;
    old = ref_mem[a];
    merged = old;
    if (w)
      for (int i = 0; i < 4; i++)
        if (m[i]) merged = (merged & ~(32'hFF << (8 * i))) | (d & (32'hFF << (8 * i)));
    exp_valid = r;
`ifdef BANKED_MEM_SYNC_BYPASS_EN
    if (r) exp_data = merged;
`else
    if (r) exp_data = old;
`endif
    if (w) ref_mem[a] = merged;
  endtask
  function automatic logic [31:0] pat(input int a);
    return (32'(a) * 32'h01010101) ^ 32'h5A3C_96E1;
  endfunction
  initial begin
    logic [31:0] col_exp;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    // Reset both instances for two cycles, then watch the clear sweep; commands during it are ignored.
    reset = 1'b1; reset2 = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive2(0, 0, 0, 0);
    tick; tick;
    chk("reset_ready", 32'(ready), 0);
    chk("reset_valid", 32'(rd_valid), 0);
    chk("reset_data", data_out, 0);
    chk("reset_err", 32'(addr_err), 0);
    reset = 1'b0; reset2 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      drive(1, 1, 4'hF, 4'(k - 1), 32'hFFFF_FFFF);
      tick;
      chk($sformatf("init_ready_%0d", k), 32'(ready), 32'(k == 16));
      chk($sformatf("init_valid_%0d", k), 32'(rd_valid), 0);
    end
    chk("d12_ready", 32'(ready2), 1);
    // Table: cleared memory, masked overwrite, then data hold with no read.
    for (int a = 0; a < 16; a++) tbl.push_back('{1'b1, 1'b0, 4'h0, 4'(a), 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 32'hDE22BE44});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'hDE22BE44});
    tbl.push_back('{1'b0, 1'b1, 4'h0, 4'd3, 32'hFFFFFFFF, 1'b0, 32'hDE22BE44});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 32'hDE22BE44});
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
      chk($sformatf("tbl%0d_err", i), 32'(addr_err), 0);
    end
    // Random fill, back-to-back read-out, then mixed random traffic against the scoreboard.
    for (int a = 0; a < 16; a++) apply(0, 1, 4'($urandom_range(0, 15)), 4'(a), $urandom);
    for (int a = 0; a < 16; a++) begin
      apply(1, 0, 0, 4'(a), 0);
      chk($sformatf("b2b_valid_%0d", a), 32'(rd_valid), 1);
      chk($sformatf("b2b_data_%0d", a), data_out, exp_data);
    end
    for (int n = 0; n < 200; n++) begin
      apply(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom);
      chk($sformatf("rnd_valid_%0d", n), 32'(rd_valid), 32'(exp_valid));
      chk($sformatf("rnd_data_%0d", n), data_out, exp_data);
    end
    // Same-address collision.
    apply(0, 1, 4'hF, 4'd5, 32'hAAAAAAAA);
    apply(1, 1, 4'h3, 4'd5, 32'h55555555);
`ifdef BANKED_MEM_SYNC_BYPASS_EN
    col_exp = 32'hAAAA5555;
`else
    col_exp = 32'hAAAAAAAA;
`endif
    chk("collision_data", data_out, col_exp);
    apply(1, 0, 0, 4'd5, 0);
    chk("collision_after", data_out, 32'hAAAA5555);
    drive(0, 0, 0, 0, 0);
    // DEPTH=12 instance: out-of-range commands.
    for (int a = 0; a < 12; a++) begin
      drive2(0, 1, 4'(a), pat(a));
      tick;
    end
    drive2(1, 0, 4'd11, 0); tick;
    chk("d12_rd11", data_out2, pat(11));
    drive2(0, 1, 4'd13, 32'hFFFFFFFF); tick;
    chk("d12_wr13_err", 32'(addr_err2), 1);
    chk("d12_wr13_valid", 32'(rd_valid2), 0);
    drive2(1, 0, 4'd13, 0); tick;
    chk("d12_rd13_err", 32'(addr_err2), 1);
    chk("d12_rd13_valid", 32'(rd_valid2), 1);
    chk("d12_rd13_data", data_out2, 0);
    drive2(0, 0, 0, 0); tick;
    chk("d12_err_pulse", 32'(addr_err2), 0);
    chk("d12_valid_pulse", 32'(rd_valid2), 0);
    drive2(0, 1, 4'd12, 32'hFFFFFFFF); tick;
    chk("d12_wr12_err", 32'(addr_err2), 1);
    for (int a = 0; a < 12; a++) begin
      drive2(1, 0, 4'(a), 0);
      tick;
      chk($sformatf("d12_keep_%0d", a), data_out2, pat(a));
      chk($sformatf("d12_keep_err_%0d", a), 32'(addr_err2), 0);
    end
    drive2(0, 0, 0, 0);
    // Reset during a RUN read, then again partway through INIT.
    apply(1, 0, 0, 4'd5, 0);
    chk("pre_reset_data", data_out, 32'hAAAA5555);
    drive(1, 0, 0, 4'd5, 0);
    reset = 1'b1; tick;
    chk("run_reset_data", data_out, 0);
    chk("run_reset_valid", 32'(rd_valid), 0);
    chk("run_reset_ready", 32'(ready), 0);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick;
      chk($sformatf("mid_init_valid_%0d", k), 32'(rd_valid), 0);
    end
    reset = 1'b1; tick;
    chk("init_reset_ready", 32'(ready), 0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      drive(1, 1, 4'hF, 4'(k - 1), 32'hFFFF_FFFF);
      tick;
      chk($sformatf("reinit_ready_%0d", k), 32'(ready), 32'(k == 16));
      chk($sformatf("reinit_valid_%0d", k), 32'(rd_valid), 0);
    end
    foreach (ref_mem[i]) ref_mem[i] = '0;
    for (int a = 0; a < 16; a++) begin
      apply(1, 0, 0, 4'(a), 0);
      chk($sformatf("reinit_clear_%0d", a), data_out, 32'h0);
      chk($sformatf("reinit_rvalid_%0d", a), 32'(rd_valid), 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
